// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// FSM state encoding, NOP word and default word-address width.
package imem_loader_pkg;

    localparam int unsigned IMEM_AW = 6;
    localparam logic [31:0] IMEM_NOP = '0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader; the source
// (UART receiver or testbench) is the master.
interface imem_loader_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/imem_loader_ram.sv
// 2**AW x 32 instruction RAM: synchronous write port, combinational read
// port. Contents are deliberately not cleared by reset.
module imem_ram #(
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Writable instruction memory with byte-stream boot loader; holds the CPU
// in reset until a load completes. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned AW = IMEM_AW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    imem_loader_if.slave rx,
    input  logic [31:0]  a,
    output logic [31:0]  inst,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         cpu_hold
);

    state_t        state, state_n;
    logic          loaded;
    logic [1:0]    byte_idx;
    logic [AW-1:0] waddr;
    logic [AW-1:0] last_addr;
    logic [23:0]   shreg;
    logic          hs;
    logic          last_word;
    logic          we;
    logic [31:0]   rdata;
    logic          unused_a;

    assign hs        = rx.rx_valid & rx.rx_ready;
    assign last_word = (byte_idx == 2'd3) && (waddr == last_addr);
    assign we        = (state == ST_DATA) && hs && (byte_idx == 2'd3);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (start) state_n = ST_LEN;
            ST_LEN:  if (hs) state_n = ST_DATA;
            ST_DATA: begin
                if (hs && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_n = ST_CHK;
`else
                    state_n = ST_FIN;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK:  if (hs) state_n = (csum == rx.rx_data) ? ST_FIN : ST_IDLE;
`endif
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        rx.rx_ready = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            ST_IDLE: busy = 1'b0;
            ST_LEN:  rx.rx_ready = 1'b1;
            ST_DATA: rx.rx_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK:  rx.rx_ready = 1'b1;
`endif
            ST_FIN:  done = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    // Word assembler: the first three bytes park in shreg; the fourth is
    // concatenated directly into the write data so the word lands this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            loaded    <= 1'b0;
            byte_idx  <= '0;
            waddr     <= '0;
            last_addr <= '0;
            shreg     <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) loaded <= 1'b0;
                ST_LEN: begin
                    if (hs) begin
                        last_addr <= rx.rx_data[AW-1:0];
                        byte_idx  <= '0;
                        waddr     <= '0;
                    end
                end
                ST_DATA: begin
                    if (hs) begin
                        shreg    <= {shreg[15:0], rx.rx_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3 && !last_word) begin
                            waddr <= waddr + AW'(1);
                        end
                    end
                end
                ST_FIN:  loaded <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
            csum  <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                err_q <= 1'b0;
            end
            if (state == ST_CHK && hs && csum != rx.rx_data) begin
                err_q <= 1'b1;
            end
            if (state == ST_LEN && hs) begin
                csum <= rx.rx_data;
            end else if (state == ST_DATA && hs) begin
                csum <= csum ^ rx.rx_data;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    imem_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata ({shreg, rx.rx_data}),
        .raddr (a[AW+1:2]),
        .rdata (rdata)
    );

    assign unused_a = ^{a[31:AW+2], a[1:0]};
    assign inst     = busy ? IMEM_NOP : rdata;
    assign cpu_hold = ~loaded | busy;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writable instruction memory plus a byte-stream boot loader. It is the write-side counterpart of the fixed 64-word instruction ROM.
- An external byte source (UART receiver or testbench) streams a program in. The FSM assembles bytes into 32-bit words and writes them to a 64x32 RAM.
- The CPU fetch side reads the RAM combinationally by byte address. The CPU is held in reset until a load completes.

Parameters:
- AW, 6, word-address width; depth = 2**AW words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load. Ignored while busy.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte; transfer happens when rx_valid&rx_ready.
- a  in  32  CPU fetch byte address.
- inst  out  32  instruction at a.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on successful load completion.
- err  out  1  sticky checksum error (0 when feature is compiled out).
- cpu_hold  out  1  holds the CPU in reset.

Behaviour:
- Reset values: rx_ready=0, busy=0, done=0, err=0, cpu_hold=1. Internal loaded flag=0, FSM=IDLE. RAM contents are not cleared by reset.
- Output decode: cpu_hold = ~loaded | busy. busy = (state != IDLE).
- Fetch read: inst = ram[a[AW+1:2]], combinational, zero latency. a[1:0] and a[31:AW+2] are ignored, so addresses wrap modulo depth.
- While busy, inst = 32'h00000000 (NOP) regardless of RAM contents.
- FSM states:
  - IDLE: rx_ready=0. On start go to LEN and clear loaded and err.
  - LEN: rx_ready=1. On handshake, latch last_addr = rx_data[AW-1:0] (word count minus 1; upper bits ignored). Clear byte_idx and waddr. Go to DATA.
  - DATA: rx_ready=1. Each handshake shifts the byte in big-endian order: first byte -> [31:24], fourth byte -> [7:0]. byte_idx increments mod 4.
    - On the 4th byte, write the assembled word to ram[waddr] in that same cycle, so it is readable the next cycle.
    - If waddr==last_addr, go to CHK (feature on) or FIN (feature off). Otherwise waddr+1.
  - CHK: see Optional Feature.
  - FIN: rx_ready=0, done=1 for exactly one cycle, loaded=1. Go to IDLE.
- rx_valid without handshake (state IDLE or FIN) is ignored; no byte is consumed.
- Stalls: rx_valid low for any number of cycles between bytes is legal; the FSM simply waits.
- Start while busy: ignored.
- rst mid-load: FSM returns to IDLE and loaded=0, so cpu_hold=1. RAM words already written remain.
- Zero-length load is impossible: a LEN byte of 0 means 1 word. 8'h3F means 64 words (AW=6).
- Throughput: one byte per cycle at full rate. Minimum load time = 1 + 4*N + 1 cycles (+1 with checksum).

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR over the LEN byte and all data bytes is kept.
  - CHK accepts one extra byte with rx_ready=1.
  - Match: go to FIN.
  - Mismatch: err=1 (sticky until the next start or rst), no done pulse, loaded stays 0, go to IDLE. The CPU stays held.
- Not defined: the CHK state and XOR register do not exist, and err is tied to 0.

Decomposition:
- Shared package/header holds:
  - the FSM state encodings (IDLE=0, LEN=1, DATA=2, CHK=3, FIN=4, 3-bit);
  - IMEM_NOP = 32'h00000000;
  - the default AW.
- One sub-module: imem_ram, a 2**AW x 32 RAM with a synchronous write port and a combinational read port. The FSM and word assembler stay in the top module.

Test Plan:
- Basic load:
  - Stimulus: start, then bytes 02, 14,00,04,01, 14,00,08,02, 14,00,0C,03 (feature off).
  - Required: done pulses once. inst at a=0x0/0x4/0x8 = 14000401/14000802/14000C03. cpu_hold falls the cycle after done.
- Handshake stalls:
  - Stimulus: the same stream with rx_valid dropped randomly for 0-5 cycles between bytes.
  - Required: identical RAM contents. No byte is accepted while rx_valid=0.
- Wrap and ignore:
  - Stimulus: after the load, set a=0x100 and a=0x103.
  - Required: both return 14000401. inst=0 on every cycle while busy.
- Reset mid-load:
  - Stimulus: assert rst after the 6th byte.
  - Required: busy=0, cpu_hold=1, done never pulses. A full reload then succeeds.
- Start while busy:
  - Stimulus: pulse start in DATA.
  - Required: no state change. The load completes normally.
- Checksum (feature on):
  - Stimulus: LEN 00, data 40,00,08,41, then checksum 00^40^00^08^41=09.
  - Required: done=1, err=0.
  - Stimulus: checksum 0A instead.
  - Required: err=1, no done, cpu_hold stays 1.
